// File: rtl/decode_stage_seq_pkg.sv
// Shared definitions for the registered decode stage: opcodes, ALU selects,
// active-low write-enable levels and the LM/SM sequencer state encoding.
package decode_stage_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_NAND = 1'b1;

  // Write enables are active low throughout the pipeline.
  localparam logic WEN_ON  = 1'b0;
  localparam logic WEN_OFF = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

endpackage

// File: rtl/decode_stage_seq_pri_enc.sv
// Lowest-set-bit priority encoder used by the LM/SM micro-sequencer.
module lmsm_pri_enc
  import decode_stage_seq_pkg::*;
#(
  parameter int MASK_W = 8,
  parameter int REG_AW = 3
) (
  input  logic [MASK_W-1:0] i_mask,
  output logic [REG_AW-1:0] o_index,
  output logic              o_found,
  output logic [MASK_W-1:0] o_onehot_clear
);

  // Scan from the top so the lowest set bit is the last one to win.
  always_comb begin
    o_index = {REG_AW{1'b0}};
    for (int i = MASK_W - 1; i >= 0; i--) begin
      o_index = i_mask[i] ? REG_AW'(i) : o_index;
    end
  end

  assign o_found        = |i_mask;
  assign o_onehot_clear = i_mask & (~i_mask + {{(MASK_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/decode_stage_seq.sv
// Registered decode stage (pipe1 -> pipe2) with valid/ready handshake, flush
// and an LM/SM micro-sequencer emitting one memory micro-op per mask bit.
module decode_stage_seq
  import decode_stage_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] fromPipe1PC,
  input  logic [DATA_W-1:0] fromPipe1IR,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] PC_Imm,
  output logic [REG_AW-1:0] rA1,
  output logic [REG_AW-1:0] rA2,
  output logic [REG_AW-1:0] wA,
  output logic [DATA_W-1:0] Sext_Imm6,
  output logic [DATA_W-1:0] Imm970,
  output logic              Mex1,
  output logic              Mex2,
  output logic              alu_ctrl,
  output logic              wCCR,
  output logic              wMem,
  output logic              wRF,
  output logic              MregWB,
  output logic [1:0]        cond,
  output logic              uop_last
);

  state_e            r_state, w_nxt_state;
  logic              r_out_valid, w_nxt_valid;
  logic [MASK_W-1:0] r_mask, w_nxt_mask;
  logic [REG_AW:0]   r_off, w_nxt_off;
  logic              r_is_lm, w_nxt_is_lm;

  logic [DATA_W-1:0] r_pc_imm, w_nxt_pc_imm;
  logic [REG_AW-1:0] r_ra1, w_nxt_ra1;
  logic [REG_AW-1:0] r_ra2, w_nxt_ra2;
  logic [REG_AW-1:0] r_wa, w_nxt_wa;
  logic [DATA_W-1:0] r_sext, w_nxt_sext;
  logic [DATA_W-1:0] r_imm970, w_nxt_imm970;
  logic              r_mex1, w_nxt_mex1;
  logic              r_mex2, w_nxt_mex2;
  logic              r_alu, w_nxt_alu;
  logic              r_wccr, w_nxt_wccr;
  logic              r_wmem, w_nxt_wmem;
  logic              r_wrf, w_nxt_wrf;
  logic              r_mregwb, w_nxt_mregwb;
  logic [1:0]        r_cond, w_nxt_cond;
  logic              r_last, w_nxt_last;

  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_fa, w_fb, w_fc;
  logic [DATA_W-1:0] w_sext6, w_sext9, w_imm970;
  logic              w_in_ready, w_accept, w_adv;
  logic [MASK_W-1:0] w_enc_in, w_enc_onehot, w_enc_rest;
  logic [REG_AW-1:0] w_enc_idx;
  logic              w_enc_found;

  assign w_op     = fromPipe1IR[15:12];
  assign w_fa     = REG_AW'(fromPipe1IR[11:9]);
  assign w_fb     = REG_AW'(fromPipe1IR[8:6]);
  assign w_fc     = REG_AW'(fromPipe1IR[5:3]);
  assign w_sext6  = {{(DATA_W-6){fromPipe1IR[5]}}, fromPipe1IR[5:0]};
  assign w_sext9  = {{(DATA_W-9){fromPipe1IR[8]}}, fromPipe1IR[8:0]};
  assign w_imm970 = {fromPipe1IR[8:0], {(DATA_W-9){1'b0}}};

  assign w_adv      = !r_out_valid || out_ready;
  assign w_in_ready = reset && (r_state == ST_IDLE) && w_adv;
  assign w_accept   = in_valid && w_in_ready && !flush;

  // The encoder looks at the fresh IR mask on acceptance, and at the bits
  // still pending while a sequence is running.
  assign w_enc_in   = (r_state == ST_SEQ) ? r_mask : fromPipe1IR[MASK_W-1:0];
  assign w_enc_rest = w_enc_in & ~w_enc_onehot;

  lmsm_pri_enc #(
    .MASK_W (MASK_W),
    .REG_AW (REG_AW)
  ) u_pri_enc (
    .i_mask         (w_enc_in),
    .o_index        (w_enc_idx),
    .o_found        (w_enc_found),
    .o_onehot_clear (w_enc_onehot)
  );

  // Next-state and next-output computation for pipe2 and the sequencer.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_valid  = r_out_valid;
    w_nxt_mask   = r_mask;
    w_nxt_off    = r_off;
    w_nxt_is_lm  = r_is_lm;
    w_nxt_pc_imm = r_pc_imm;
    w_nxt_ra1    = r_ra1;
    w_nxt_ra2    = r_ra2;
    w_nxt_wa     = r_wa;
    w_nxt_sext   = r_sext;
    w_nxt_imm970 = r_imm970;
    w_nxt_mex1   = r_mex1;
    w_nxt_mex2   = r_mex2;
    w_nxt_alu    = r_alu;
    w_nxt_wccr   = r_wccr;
    w_nxt_wmem   = r_wmem;
    w_nxt_wrf    = r_wrf;
    w_nxt_mregwb = r_mregwb;
    w_nxt_cond   = r_cond;
    w_nxt_last   = r_last;

    if (flush) begin
      w_nxt_valid = 1'b0;
      w_nxt_state = ST_IDLE;
      w_nxt_mask  = {MASK_W{1'b0}};
      w_nxt_off   = {(REG_AW+1){1'b0}};
    end else if ((r_state == ST_SEQ) && w_adv) begin
      // Previous micro-op accepted: emit the next pending bit; the
      // instruction-level fields stay as captured.
      w_nxt_valid = 1'b1;
      w_nxt_sext  = DATA_W'(r_off);
      if (r_is_lm) begin
        w_nxt_wa = w_enc_idx;
      end else begin
        w_nxt_ra2 = w_enc_idx;
      end
      w_nxt_mask  = w_enc_rest;
      w_nxt_off   = r_off + {{REG_AW{1'b0}}, 1'b1};
      w_nxt_last  = (w_enc_rest == {MASK_W{1'b0}});
      w_nxt_state = (w_enc_rest == {MASK_W{1'b0}}) ? ST_IDLE : ST_SEQ;
    end else if (w_accept) begin
      w_nxt_valid  = 1'b1;
      w_nxt_pc_imm = fromPipe1PC + ((w_op == OP_JAL) ? w_sext9 : w_sext6);
      w_nxt_ra1    = {REG_AW{1'b0}};
      w_nxt_ra2    = {REG_AW{1'b0}};
      w_nxt_wa     = {REG_AW{1'b0}};
      w_nxt_sext   = w_sext6;
      w_nxt_imm970 = w_imm970;
      w_nxt_mex1   = 1'b0;
      w_nxt_mex2   = 1'b0;
      w_nxt_alu    = ALU_ADD;
      w_nxt_wccr   = WEN_OFF;
      w_nxt_wmem   = WEN_OFF;
      w_nxt_wrf    = WEN_OFF;
      w_nxt_mregwb = 1'b0;
      w_nxt_cond   = 2'b00;
      w_nxt_last   = 1'b1;
      case (w_op)
        OP_ADD, OP_NDU: begin
          w_nxt_ra1    = w_fa;
          w_nxt_ra2    = w_fb;
          w_nxt_wa     = w_fc;
          w_nxt_wccr   = WEN_ON;
          w_nxt_wrf    = WEN_ON;
          w_nxt_mregwb = 1'b1;
          w_nxt_alu    = (w_op == OP_NDU) ? ALU_NAND : ALU_ADD;
          w_nxt_cond   = fromPipe1IR[1:0];
        end
        OP_ADI: begin
          w_nxt_ra1    = w_fa;
          w_nxt_wa     = w_fb;
          w_nxt_mex2   = 1'b1;
          w_nxt_wccr   = WEN_ON;
          w_nxt_wrf    = WEN_ON;
          w_nxt_mregwb = 1'b1;
        end
        OP_LHI: begin
          w_nxt_wa     = w_fa;
          w_nxt_wrf    = WEN_ON;
          w_nxt_mregwb = 1'b1;
        end
        OP_LW: begin
          w_nxt_wa   = w_fa;
          w_nxt_ra2  = w_fb;
          w_nxt_mex1 = 1'b1;
          w_nxt_wccr = WEN_ON;
          w_nxt_wrf  = WEN_ON;
        end
        OP_SW: begin
          w_nxt_ra1  = w_fa;
          w_nxt_ra2  = w_fb;
          w_nxt_mex1 = 1'b1;
          w_nxt_wmem = WEN_ON;
        end
        OP_BEQ: begin
          w_nxt_ra1 = w_fa;
          w_nxt_ra2 = w_fb;
        end
        OP_JAL: begin
          w_nxt_wa  = w_fa;
          w_nxt_wrf = WEN_ON;
        end
        OP_JLR: begin
          w_nxt_wa  = w_fa;
          w_nxt_ra2 = w_fb;
          w_nxt_wrf = WEN_ON;
        end
        OP_LM, OP_SM: begin
          w_nxt_is_lm = (w_op == OP_LM);
          w_nxt_ra1   = w_fa;
          w_nxt_mex1  = 1'b1;
          w_nxt_sext  = {DATA_W{1'b0}};
          if (w_op == OP_LM) begin
            w_nxt_wa  = w_enc_idx;
            w_nxt_wrf = WEN_ON;
          end else begin
            w_nxt_ra2  = w_enc_idx;
            w_nxt_wmem = WEN_ON;
          end
          // An empty mask consumes the instruction without a micro-op.
          w_nxt_valid = w_enc_found;
          w_nxt_last  = (w_enc_rest == {MASK_W{1'b0}});
          w_nxt_mask  = w_enc_rest;
          w_nxt_off   = {{REG_AW{1'b0}}, 1'b1};
          w_nxt_state = (w_enc_rest == {MASK_W{1'b0}}) ? ST_IDLE : ST_SEQ;
        end
        default: begin
          w_nxt_valid = 1'b1;
        end
      endcase
    end else if (w_adv) begin
      w_nxt_valid = 1'b0;
    end else begin
      w_nxt_valid = r_out_valid;
    end
  end

  // Pipe2 and sequencer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_mask      <= {MASK_W{1'b0}};
      r_off       <= {(REG_AW+1){1'b0}};
      r_is_lm     <= 1'b0;
      r_pc_imm    <= {DATA_W{1'b0}};
      r_ra1       <= {REG_AW{1'b0}};
      r_ra2       <= {REG_AW{1'b0}};
      r_wa        <= {REG_AW{1'b0}};
      r_sext      <= {DATA_W{1'b0}};
      r_imm970    <= {DATA_W{1'b0}};
      r_mex1      <= 1'b0;
      r_mex2      <= 1'b0;
      r_alu       <= 1'b0;
      r_wccr      <= WEN_OFF;
      r_wmem      <= WEN_OFF;
      r_wrf       <= WEN_OFF;
      r_mregwb    <= 1'b0;
      r_cond      <= 2'b00;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= w_nxt_valid;
      r_mask      <= w_nxt_mask;
      r_off       <= w_nxt_off;
      r_is_lm     <= w_nxt_is_lm;
      r_pc_imm    <= w_nxt_pc_imm;
      r_ra1       <= w_nxt_ra1;
      r_ra2       <= w_nxt_ra2;
      r_wa        <= w_nxt_wa;
      r_sext      <= w_nxt_sext;
      r_imm970    <= w_nxt_imm970;
      r_mex1      <= w_nxt_mex1;
      r_mex2      <= w_nxt_mex2;
      r_alu       <= w_nxt_alu;
      r_wccr      <= w_nxt_wccr;
      r_wmem      <= w_nxt_wmem;
      r_wrf       <= w_nxt_wrf;
      r_mregwb    <= w_nxt_mregwb;
      r_cond      <= w_nxt_cond;
      r_last      <= w_nxt_last;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign PC_Imm    = r_pc_imm;
  assign rA1       = r_ra1;
  assign rA2       = r_ra2;
  assign wA        = r_wa;
  assign Sext_Imm6 = r_sext;
  assign Imm970    = r_imm970;
  assign Mex1      = r_mex1;
  assign Mex2      = r_mex2;
  assign alu_ctrl  = r_alu;
  assign wCCR      = r_wccr;
  assign wMem      = r_wmem;
  assign wRF       = r_wrf;
  assign MregWB    = r_mregwb;
  assign cond      = r_cond;
  assign uop_last  = r_last;

endmodule

// File: tb/tb_decode_stage_seq.sv
// Self-checking bench for decode_stage_seq: directed scenarios plus random
// traffic against an instruction-level reference model.
module tb_decode_stage_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] fromPipe1PC, fromPipe1IR, PC_Imm, Sext_Imm6, Imm970;
  logic [2:0]  rA1, rA2, wA;
  logic        Mex1, Mex2, alu_ctrl, wCCR, wMem, wRF, MregWB, uop_last;
  logic [1:0]  cond;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [15:0] pc_imm, sext, imm970;
    logic [2:0]  ra1, ra2, wa;
    logic        mex1, mex2, alu, wccr, wmem, wrf, mregwb, last;
    logic [1:0]  cond;
  } uop_t;

  uop_t pending[$];
  uop_t exp_cur;
  logic exp_valid = 1'b0;

  logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                           4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hA};
  logic [2:0] lm_wa [3] = '{3'd0, 3'd2, 3'd5};

  decode_stage_seq #(.DATA_W(16), .REG_AW(3), .MASK_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fromPipe1PC(fromPipe1PC), .fromPipe1IR(fromPipe1IR), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .PC_Imm(PC_Imm),
    .rA1(rA1), .rA2(rA2), .wA(wA), .Sext_Imm6(Sext_Imm6), .Imm970(Imm970),
    .Mex1(Mex1), .Mex2(Mex2), .alu_ctrl(alu_ctrl), .wCCR(wCCR), .wMem(wMem),
    .wRF(wRF), .MregWB(MregWB), .cond(cond), .uop_last(uop_last)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand one accepted instruction into the micro-ops it must produce.
  task automatic expand(input logic [15:0] pc, input logic [15:0] ir);
    uop_t u, m;
    int off;
    logic [3:0] op;
    op = ir[15:12];
    u.sext   = {{10{ir[5]}}, ir[5:0]};
    u.pc_imm = (op == 4'h8) ? pc + {{7{ir[8]}}, ir[8:0]} : pc + u.sext;
    u.imm970 = {ir[8:0], 7'b0};
    u.ra1 = 3'd0; u.ra2 = 3'd0; u.wa = 3'd0;
    u.mex1 = 1'b0; u.mex2 = 1'b0; u.alu = 1'b0;
    u.wccr = 1'b1; u.wmem = 1'b1; u.wrf = 1'b1;
    u.mregwb = 1'b0; u.cond = 2'b00; u.last = 1'b1;
    case (op)
      4'h0, 4'h2: begin
        u.ra1 = ir[11:9]; u.ra2 = ir[8:6]; u.wa = ir[5:3];
        u.wccr = 1'b0; u.wrf = 1'b0; u.mregwb = 1'b1;
        u.alu = (op == 4'h2); u.cond = ir[1:0];
      end
      4'h1: begin u.ra1 = ir[11:9]; u.wa = ir[8:6]; u.mex2 = 1'b1; u.wccr = 1'b0; u.wrf = 1'b0; u.mregwb = 1'b1; end
      4'h3: begin u.wa = ir[11:9]; u.wrf = 1'b0; u.mregwb = 1'b1; end
      4'h4: begin u.wa = ir[11:9]; u.ra2 = ir[8:6]; u.mex1 = 1'b1; u.wccr = 1'b0; u.wrf = 1'b0; end
      4'h5: begin u.ra1 = ir[11:9]; u.ra2 = ir[8:6]; u.mex1 = 1'b1; u.wmem = 1'b0; end
      4'hC: begin u.ra1 = ir[11:9]; u.ra2 = ir[8:6]; end
      4'h8: begin u.wa = ir[11:9]; u.wrf = 1'b0; end
      4'h9: begin u.wa = ir[11:9]; u.ra2 = ir[8:6]; u.wrf = 1'b0; end
      default: begin end
    endcase
    if (op == 4'h6 || op == 4'h7) begin
      off = 0;
      for (int b = 0; b < 8; b++) begin
        if (ir[b]) begin
          m = u;
          m.ra1 = ir[11:9]; m.mex1 = 1'b1; m.sext = 16'(off); m.last = 1'b0;
          if (op == 4'h6) begin m.wa = b[2:0]; m.wrf = 1'b0; m.mregwb = 1'b0; end
          else begin m.ra2 = b[2:0]; m.wmem = 1'b0; end
          pending.push_back(m);
          off++;
        end
      end
      if (pending.size() > 0) begin
        m = pending.pop_back();
        m.last = 1'b1;
        pending.push_back(m);
      end
    end else begin
      pending.push_back(u);
    end
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check pipe2.
  task automatic run_cycle(input logic v, input logic [15:0] pc, input logic [15:0] ir,
                           input logic fl, input logic ordy);
    logic exp_rdy, acc;
    @(negedge clk);
    in_valid = v; fromPipe1PC = pc; fromPipe1IR = ir; flush = fl; out_ready = ordy;
    #1;
    exp_rdy = (pending.size() == 0) && (!exp_valid || ordy);
    check_val("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_valid = 1'b0;
      pending.delete();
    end else if (exp_valid && !ordy) begin
      exp_valid = 1'b1;
    end else if (pending.size() > 0) begin
      exp_cur = pending.pop_front();
      exp_valid = 1'b1;
    end else if (acc) begin
      expand(pc, ir);
      exp_valid = (pending.size() > 0);
      if (exp_valid) exp_cur = pending.pop_front();
    end else begin
      exp_valid = 1'b0;
    end
    check_val("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check_val("pc_imm", PC_Imm, exp_cur.pc_imm);
      check_val("sext_imm6", Sext_Imm6, exp_cur.sext);
      check_val("imm970", Imm970, exp_cur.imm970);
      check_val("addr", {rA1, rA2, wA}, {exp_cur.ra1, exp_cur.ra2, exp_cur.wa});
      check_val("ctl", {Mex1, Mex2, alu_ctrl, wCCR, wMem, wRF, MregWB, cond, uop_last},
                {exp_cur.mex1, exp_cur.mex2, exp_cur.alu, exp_cur.wccr, exp_cur.wmem,
                 exp_cur.wrf, exp_cur.mregwb, exp_cur.cond, exp_cur.last});
    end
  endtask

  initial begin
    logic [15:0] ir;
    logic [3:0]  op;
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fromPipe1PC = 16'h0000; fromPipe1IR = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_wen", {wRF, wMem, wCCR}, 3'b111);
    check_val("rst_in_ready", in_ready, 1'b0);
    check_val("rst_data", {PC_Imm, Sext_Imm6, Imm970, rA1, rA2, wA}, 57'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rel_in_ready", in_ready, 1'b1);

    run_cycle(1'b1, 16'h0010, 16'h0298, 1'b0, 1'b1);
    check_val("add_regs", {rA1, rA2, wA}, {3'd1, 3'd2, 3'd3});
    check_val("add_ctl", {wRF, wCCR, alu_ctrl, cond}, 5'b00000);

    run_cycle(1'b1, 16'h0005, 16'h81FF, 1'b0, 1'b1);
    check_val("jal_pc_imm", PC_Imm, 16'h0004);
    check_val("jal_wa_wrf", {wA, wRF}, 4'b0000);

    run_cycle(1'b1, 16'h0020, 16'h6A25, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check_val("lm_wa", wA, lm_wa[k]);
      check_val("lm_off", Sext_Imm6, k);
      check_val("lm_last", uop_last, (k == 2));
      if (k < 2) run_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    end

    run_cycle(1'b1, 16'h0030, 16'h7403, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      check_val("sm_hold", {rA2, Sext_Imm6}, {3'd0, 16'd0});
    end
    run_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check_val("sm_second", {rA2, Sext_Imm6, uop_last}, {3'd1, 16'd1, 1'b1});

    run_cycle(1'b1, 16'h0040, 16'h62FF, 1'b0, 1'b1);
    run_cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    run_cycle(1'b1, 16'h0050, 16'h0298, 1'b1, 1'b1);
    check_val("flush_valid", out_valid, 1'b0);
    run_cycle(1'b1, 16'h0060, 16'h0298, 1'b0, 1'b1);
    check_val("post_flush_add", {out_valid, rA1, rA2, wA}, {1'b1, 3'd1, 3'd2, 3'd3});

    run_cycle(1'b1, 16'h0070, 16'h6E00, 1'b0, 1'b1);
    run_cycle(1'b1, 16'h0080, 16'hF123, 1'b0, 1'b1);

    for (int n = 0; n < 3000; n++) begin
      op = ops[$urandom_range(0, 13)];
      ir = {op, 12'($urandom)};
      if (op == 4'h6 || op == 4'h7) begin
        case ($urandom_range(0, 3))
          0: ir[7:0] = 8'h00;
          1: ir[7:0] = 8'(1 << $urandom_range(0, 7));
          default: ir[7:0] = ir[7:0];
        endcase
      end
      run_cycle($urandom_range(0, 9) < 7, 16'($urandom), ir,
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage_seq.md
Name: decode_stage_seq

Overview:
Parametrised successor to the combinational decode logic: a registered decode stage (pipe1 → pipe2) with a valid/ready handshake, flush, and a micro-sequencer that expands LM/SM into one load/store micro-op per set mask bit. It sits between the fetch pipeline register and register-read/execute. It emits register addresses, immediates, PC+offset and active-low write enables consistent with the rest of the pipeline.

Parameters:
DATA_W, 16, datapath/PC/IR width
REG_AW, 3, register-address width (2**REG_AW registers)
MASK_W, 8, LM/SM register-mask width, taken from IR[MASK_W-1:0]; MASK_W <= 2**REG_AW

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  pipe1 holds a valid instruction
in_ready  out  1  stage accepts pipe1 this cycle
fromPipe1PC  in  DATA_W  instruction PC
fromPipe1IR  in  DATA_W  instruction word
flush  in  1  kill stage contents and any LM/SM sequence
out_valid  out  1  pipe2 outputs valid
out_ready  in  1  downstream accepts pipe2
PC_Imm  out  DATA_W  PC + sext(imm9) for JAL, PC + sext(imm6) otherwise
rA1, rA2, wA  out  REG_AW each  read addresses, write address
Sext_Imm6  out  DATA_W  sext(IR[5:0]); during LM/SM, the micro-op offset
Imm970  out  DATA_W  IR[8:0] placed in bits [DATA_W-1:DATA_W-9], zeros below
Mex1, Mex2, alu_ctrl  out  1 each  ALU operand selects; 0 = add, 1 = nand
wCCR, wMem, wRF  out  1 each  active-low write enables (0 = write)
MregWB  out  1  1 = write back ALU result, 0 = write back memory data
cond  out  2  IR[1:0] for ADD/NDU family; 00 otherwise
uop_last  out  1  final micro-op of an instruction (1 for non-LM/SM)

Behaviour:
- Reset (reset == 0 at a clk edge):
  - out_valid = 0, state = IDLE, mask/offset registers = 0.
  - All data outputs 0; wCCR = wMem = wRF = 1; in_ready = 0 during the reset cycle.
- Handshake and latency:
  - Transfer occurs when in_valid && in_ready.
  - Outputs are registered with 1-cycle latency.
  - Pipe2 holds its values while out_valid && !out_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
- Opcodes (IR[15:12]):
  - ADD 0000 / NDU 0010: rA1 = IR[11:9], rA2 = IR[8:6], wA = IR[5:3]; Mex1 = Mex2 = 0; wCCR = wRF = 0; MregWB = 1; alu_ctrl = 0 for ADD, 1 for NDU.
  - ADI 0001: rA1 = IR[11:9], wA = IR[8:6], Mex2 = 1, wCCR = wRF = 0.
  - LHI 0011: wA = IR[11:9], wRF = 0, MregWB = 1.
  - LW 0100: wA = IR[11:9], rA2 = IR[8:6], Mex1 = 1, wCCR = wRF = 0, MregWB = 0.
  - SW 0101: rA1 = IR[11:9], rA2 = IR[8:6], Mex1 = 1, wMem = 0.
  - BEQ 1100: rA1 = IR[11:9], rA2 = IR[8:6], no writes.
  - JAL 1000: wA = IR[11:9], wRF = 0.
  - JLR 1001: wA = IR[11:9], rA2 = IR[8:6], wRF = 0.
  - Undefined opcode: all write enables 1 (bubble), out_valid still asserted.
- Arithmetic:
  - PC_Imm is modulo 2**DATA_W; immediates are sign-extended.
- LM 0110 / SM 0111 state machine (IDLE, SEQ):
  - On acceptance, capture base = IR[11:9], mask = IR[MASK_W-1:0], off = 0.
  - Emit one micro-op per set bit, lowest index first. Each micro-op has rA1 = base, Sext_Imm6 = off, Mex1 = 1.
  - LM micro-op: wA = bit index, wRF = 0, MregWB = 0.
  - SM micro-op: rA2 = bit index, wMem = 0.
  - After each downstream-accepted micro-op: clear that mask bit and increment off.
  - Stay in SEQ (in_ready = 0) while more than one bit remains.
  - uop_last = 1 on the final micro-op; state returns to IDLE when it is accepted.
  - Single-bit mask: one micro-op, uop_last = 1, no SEQ entry.
  - Zero mask: instruction consumed, out_valid = 0 next cycle, no micro-op.
- Flush:
  - Has priority over everything except reset.
  - Next edge: out_valid = 0, state = IDLE, mask cleared. Any in_valid in the same cycle is dropped.
- Stall mid-sequence: mask and off frozen; outputs stable.

Decomposition:
- Shared package: opcode constants (OP_ADD…OP_JLR), ALU_ADD/ALU_NAND, state encoding, and the active-low enable definitions.
- One sub-module, lmsm_pri_enc: a MASK_W-bit lowest-set-bit priority encoder with outputs index (REG_AW), found, and onehot_clear.

Test Plan:
- Reset low for 2 cycles, then high → out_valid = 0, wRF = wMem = wCCR = 1, in_ready = 1 one cycle after release.
- ADD IR = 0x0298 (RA=1, RB=2, RC=3), PC = 0x0010 → next cycle rA1 = 1, rA2 = 2, wA = 3, wRF = 0, wCCR = 0, alu_ctrl = 0, cond = 00.
- JAL IR = 0x81FF, PC = 0x0005 → PC_Imm = 0x0004 (sign-extended −1), wA = 0, wRF = 0.
- LM IR = 0x6A25 (base 5, mask 0x25), out_ready = 1 → 3 consecutive micro-ops with wA = 0/2/5 and Sext_Imm6 = 0/1/2; uop_last only on the third; in_ready = 0 for 2 cycles.
- SM mask 0x03 with out_ready = 0 for 3 cycles after the first micro-op → outputs held at rA2 = 0, off = 0; then rA2 = 1, off = 1.
- Flush asserted during the second micro-op of an LM with mask 0xFF → out_valid = 0 next cycle, state = IDLE, next instruction accepted normally.
